// File: rtl/bsg_dlatch_feeder_pkg.sv
// Shared types and helpers for the latch feeder: presenter state and pointer sizing.
package bsg_dlatch_feeder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Width of an index into n entries, never less than one bit.
  function automatic int ptr_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_dlatch_feeder_mem.sv
// FIFO storage for the latch feeder: one synchronous write port, one asynchronous read port.
module bsg_dlatch_feeder_mem
  import bsg_dlatch_feeder_pkg::*;
#(
  parameter int width_p = 16,
  parameter int els_p   = 4
) (
  input  logic                          clk_i,
  input  logic                          w_v_i,
  input  logic [ptr_width(els_p)-1:0]   w_addr_i,
  input  logic [width_p-1:0]            w_data_i,
  input  logic [ptr_width(els_p)-1:0]   r_addr_i,
  output logic [width_p-1:0]            r_data_o
);

  logic [width_p-1:0] mem [els_p];

  always_ff @(posedge clk_i) begin
    if (w_v_i) mem[w_addr_i] <= w_data_i;
  end

  assign r_data_o = mem[r_addr_i];

endmodule

// File: rtl/bsg_dlatch_feeder.sv
// Feeds a transparent latch: FIFO-buffered words, each held on data_o for hold_cycles_p cycles.
// Optional parity_o output when BSG_DLATCH_FEEDER_PARITY_EN is defined.
module bsg_dlatch_feeder
  import bsg_dlatch_feeder_pkg::*;
#(
  parameter int width_p       = 16,
  parameter int els_p         = 4,
  parameter int hold_cycles_p = 2
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         v_i,
  input  logic [width_p-1:0]           data_i,
  output logic                         ready_o,
  output logic [width_p-1:0]           data_o,
  output logic                         v_o,
  output logic                         done_o,
  output logic [$clog2(els_p+1)-1:0]   count_o
`ifdef BSG_DLATCH_FEEDER_PARITY_EN
  ,
  output logic                         parity_o
`endif
);

  localparam int PW = ptr_width(els_p);
  localparam int CW = $clog2(els_p + 1);
  localparam int HW = ptr_width(hold_cycles_p);
  localparam logic [CW-1:0] FULL      = CW'(els_p);
  localparam logic [HW-1:0] HOLD_LAST = HW'(hold_cycles_p - 1);

  state_e             state, state_next;
  logic [PW-1:0]      wptr, rptr;
  logic [HW-1:0]      hold_cnt;
  logic [width_p-1:0] head;
  logic               enq, pop, nonempty;

  bsg_dlatch_feeder_mem #(
    .width_p(width_p),
    .els_p  (els_p)
  ) mem (
    .clk_i   (clk_i),
    .w_v_i   (enq),
    .w_addr_i(wptr),
    .w_data_i(data_i),
    .r_addr_i(rptr),
    .r_data_o(head)
  );

  assign ready_o  = (count_o != FULL);
  assign enq      = v_i & ready_o;
  assign nonempty = (count_o != '0);
  // Pop when idle, or on the last hold cycle so the next word follows with no bubble.
  assign pop      = nonempty & ((state == IDLE) | done_o);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (nonempty) state_next = HOLD;
      HOLD:    if (done_o && !nonempty) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    v_o    = (state == HOLD);
    done_o = (state == HOLD) && (hold_cnt == HOLD_LAST);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr     <= '0;
      rptr     <= '0;
      count_o  <= '0;
      hold_cnt <= '0;
      data_o   <= '0;
    end else begin
      if (enq) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      if (enq && !pop)      count_o <= count_o + 1'b1;
      else if (!enq && pop) count_o <= count_o - 1'b1;
      if (pop) begin
        data_o   <= head;
        hold_cnt <= '0;
      end else if (state == HOLD && !done_o) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

`ifdef BSG_DLATCH_FEEDER_PARITY_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) parity_o <= 1'b0;
    else if (pop)   parity_o <= ^head;
  end
`endif

endmodule

// File: tb/tb_bsg_dlatch_feeder.sv
// Scoreboard bench for bsg_dlatch_feeder (hold 2 instance monitored, hold 1 instance directed).
module tb_bsg_dlatch_feeder;

  localparam int HOLD = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        v, v1;
  logic [15:0] din, din1, dout, dout1;
  logic        rdy, rdy1, vo, vo1, done, done1;
  logic [2:0]  cnt, cnt1;
`ifdef BSG_DLATCH_FEEDER_PARITY_EN
  logic        par, par1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bsg_dlatch_feeder #(.width_p(16), .els_p(4), .hold_cycles_p(HOLD)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v), .data_i(din), .ready_o(rdy),
    .data_o(dout), .v_o(vo), .done_o(done), .count_o(cnt)
`ifdef BSG_DLATCH_FEEDER_PARITY_EN
    , .parity_o(par)
`endif
  );

  bsg_dlatch_feeder #(.width_p(16), .els_p(4), .hold_cycles_p(1)) dut1 (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v1), .data_i(din1), .ready_o(rdy1),
    .data_o(dout1), .v_o(vo1), .done_o(done1), .count_o(cnt1)
`ifdef BSG_DLATCH_FEEDER_PARITY_EN
    , .parity_o(par1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor on the hold-2 instance, sampled on the falling edge.
  logic [15:0] sbq[$];
  logic        prev_v, prev_done, prev_enq, nw;
  logic [2:0]  prev_cnt;
  logic [15:0] prev_data;
  logic [31:0] exp_w;
  int          run;

  always @(negedge clk) begin
    if (!reset_n) begin
      sbq.delete();
      prev_v = 0; prev_done = 0; prev_enq = 0; prev_cnt = 0; prev_data = 0; run = 0;
    end else begin
      nw = vo && (!prev_v || prev_done);
      if ((!prev_v || prev_done) && prev_cnt != 0) chk("pop_due", vo, 1);
      if (nw) begin
        exp_w = (sbq.size() > 0) ? {16'h0, sbq.pop_front()} : 32'hDEAD_BEEF;
        chk("sb_word", dout, exp_w);
        run = 1;
      end else begin
        chk("data_hold", dout, prev_data);
        if (vo) run++;
      end
      if (done) begin
        chk("done_in_v", vo, 1);
        chk("hold_len", run, HOLD);
      end
      chk("count", cnt, int'(prev_cnt) + int'(prev_enq) - int'(nw));
      chk("ready", rdy, cnt != 3'd4);
      chk("cnt_max", cnt <= 3'd4, 1);
      prev_enq = v && rdy;
      if (prev_enq) sbq.push_back(din);
      prev_v = vo; prev_done = done; prev_cnt = cnt; prev_data = dout;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  logic [15:0] nxt;
  logic        acc, saw_full;

  initial begin
    reset_n = 0; v = 0; din = '0; v1 = 0; din1 = '0;
    #3;
    chk("rst_data", dout, 0);
    chk("rst_v", vo, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", cnt, 0);
    tick; tick;
    reset_n = 1;
    tick;
    chk("rst_ready", rdy, 1);

    // Single word: one edge latency, held two cycles, done on the second.
    v = 1; din = 16'hA5A5;
    tick;
    v = 0;
    chk("t1_cnt", cnt, 1);
    chk("t1_v_pre", vo, 0);
    tick;
    chk("t1_data", dout, 16'hA5A5);
    chk("t1_v", vo, 1);
    chk("t1_done0", done, 0);
    tick;
    chk("t1_v2", vo, 1);
    chk("t1_done1", done, 1);
    tick;
    chk("t1_idle", vo, 0);
    chk("t1_keep", dout, 16'hA5A5);

    // Continuous stream until full; ready/backpressure and order via the scoreboard.
    nxt = 16'h0001; saw_full = 0; v = 1; din = nxt;
    repeat (16) begin
      acc = rdy;
      tick;
      if (acc) nxt = nxt + 16'h1;
      din = nxt;
      if (!rdy) saw_full = 1;
    end
    v = 0;
    chk("t3_saw_full", saw_full, 1);
    for (int i = 0; i < 60 && (vo || cnt != 0); i++) tick;
    chk("t3_drain", vo || cnt != 0, 0);

    // Reset in the middle of a hold with three words queued.
    v = 1;
    for (int i = 0; i < 5; i++) begin
      din = 16'(16'h0010 + i);
      tick;
    end
    v = 0;
    for (int i = 0; i < 10 && !(cnt == 3 && vo); i++) tick;
    chk("t4_setup", cnt == 3 && vo, 1);
    reset_n = 0;
    #1;
    chk("t4_data", dout, 0);
    chk("t4_v", vo, 0);
    chk("t4_cnt", cnt, 0);
    tick;
    reset_n = 1;
    repeat (4) begin
      tick;
      chk("t4_no_stale", vo, 0);
    end
    chk("t4_cnt_after", cnt, 0);

    // hold_cycles_p = 1: a new word every cycle, done on each.
    v1 = 1; din1 = 16'h1111;
    tick;
    din1 = 16'h2222;
    tick;
    chk("t5_w1", dout1, 16'h1111);
    chk("t5_d1", done1, 1);
    din1 = 16'h3333;
    tick;
    chk("t5_w2", dout1, 16'h2222);
    chk("t5_d2", done1, 1);
    v1 = 0;
    tick;
    chk("t5_w3", dout1, 16'h3333);
    chk("t5_d3", done1, 1);
    chk("t5_v3", vo1, 1);
    tick;
    chk("t5_idle", vo1, 0);
    chk("t5_keep", dout1, 16'h3333);

`ifdef BSG_DLATCH_FEEDER_PARITY_EN
    v = 1; din = 16'h0007;
    tick;
    din = 16'h0003;
    tick;
    v = 0;
    chk("t6_d7", dout, 16'h0007);
    chk("t6_p7", par, 1);
    tick; tick;
    chk("t6_d3", dout, 16'h0003);
    chk("t6_p3", par, 0);
`endif

    for (int i = 0; i < 20 && (vo || cnt != 0); i++) tick;
    tick;
    chk("sb_left", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
